alu_seq: RTL
============

Name: alu_seq

Overview:
Parametrised, registered successor to the 4-bit combinational ALU. It keeps the same 3-bit opcode map and adds:
- WIDTH-bit operands.
- valid/ready handshakes on input and output.
- A multi-cycle iterative shift-left by a variable amount.
- An accumulator-feedback mode that chains operations on the previous result.
- Status flags: carry, zero, negative, overflow.

It sits between the operand/opcode source (AccA/AccB registers) and the result consumer.

Parameters:
WIDTH, 4, operand/result width in bits (>=2)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
in_valid  input  1  operands/opcode presented
in_ready  output  1  block can accept an operation
a  input  WIDTH  operand A (AccA)
b  input  WIDTH  operand B (AccB); shift amount for SHL
op  input  3  opcode
acc_sel  input  1  1: use previous result register as operand A instead of a
out_valid  output  1  result/flags valid
out_ready  input  1  consumer accepts result
result  output  WIDTH  operation result
carry  output  1  carry/borrow flag
zero  output  1  result == 0
negative  output  1  result[WIDTH-1]
overflow  output  1  signed overflow

Behaviour:
- Opcodes:
  - 000 AND: A&B
  - 001 NOT: ~A
  - 010 OR: A|B
  - 011 XOR: A^B
  - 100 SHL: A<<B, iterative
  - 101 ADD: A+B
  - 110 SUB: A-B
  - 111 TWOS: -A
- Reset: state IDLE, in_ready=1 once reset deasserts, out_valid=0. result, carry, zero, negative, overflow=0. Accumulator (previous-result) register=0. Reset asserted mid-operation aborts it immediately; no output is produced.
- FSM states IDLE, SHIFT, DONE.
  - IDLE: in_ready=1. On in_valid&in_ready, latch op, operand A (= acc_sel ? accumulator : a) and b.
    - Non-SHL op: compute and go to DONE; out_valid rises the next cycle (latency 1).
    - SHL: n = min(b, WIDTH) as unsigned. n=0 goes to DONE with result=A, carry=0 (latency 1). n>0 goes to SHIFT with counter=n.
  - SHIFT: one bit per cycle; carry <= working[WIDTH-1], working <= working<<1, counter-1. At counter==1, go to DONE after that shift. Total latency n+1 cycles from accept to out_valid. in_ready=0.
  - DONE: out_valid=1; result and flags held stable until out_valid&out_ready. On the handshake, go to IDLE and write the accumulator with the result. in_ready=0 in DONE (no same-cycle reissue); minimum initiation interval 2 cycles.
- Flags are computed on the final result:
  - zero = (result==0); negative = MSB.
  - Carry, per op:
    - ADD: carry-out of the WIDTH-bit sum.
    - SUB: borrow (1 iff A<B unsigned).
    - TWOS: carry-out of ~A+1 (1 iff A==0).
    - SHL: last bit shifted out.
    - Logic ops: 0.
  - overflow:
    - ADD/SUB: standard signed two's-complement overflow.
    - TWOS: 1 iff A = 1000..0.
    - All others: 0.
- Outputs are registered; no combinational path from inputs to result/flags.
- in_valid while in_ready=0 is ignored; the source must hold it.

Test Plan:
- WIDTH=4, ADD a=1111 b=0111 -> after 1 cycle: out_valid=1, result=0110, carry=1, overflow=0, zero=0, negative=0.
- SUB a=0011 b=0101 -> result=1110, carry(borrow)=1, negative=1, overflow=0. SUB a=1000 b=0001 -> result=0111, overflow=1.
- SHL a=0111 b=0011 -> in_ready low 4 cycles. out_valid on 4th cycle after accept; result=1000, carry=1. SHL b=1001 (>=WIDTH) -> result=0000, zero=1, latency 5.
- TWOS a=1000 -> result=1000, overflow=1, carry=0. TWOS a=0000 -> result=0000, carry=1, zero=1.
- Backpressure and accumulator chain:
  - ADD 0001+0001, out_ready held low 5 cycles: result=0010 stable, in_ready=0.
  - Release out_ready; then XOR acc_sel=1 b=0011 -> result=0001.
- Assert reset during SHIFT (a=0001 b=0011, after 1 shift cycle) -> out_valid=0, all outputs 0, accumulator 0.
- After deassert, in_ready=1 and a fresh AND 1100&1010 returns 1000.

Source files
------------

// File: rtl/alu_seq.sv
// alu_seq: registered WIDTH-bit ALU with valid/ready handshakes,
// an iterative variable shift-left and accumulator feedback.
//
// Ports:
//   clk, reset        rising-edge clock, async active-high reset
//   in_valid/in_ready operation handshake (op, a, b, acc_sel)
//   a, b, op          operands and 3-bit opcode; b is the SHL amount
//   acc_sel           1: operand A comes from the previous result
//   out_valid/out_ready result handshake
//   result, carry, zero, negative, overflow  registered outputs
module alu_seq #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             acc_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             negative,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MINV =
    {1'b1, {(WIDTH-1){1'b0}}};

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_NOT  = 3'b001;
  localparam logic [2:0] OP_OR   = 3'b010;
  localparam logic [2:0] OP_XOR  = 3'b011;
  localparam logic [2:0] OP_SHL  = 3'b100;
  localparam logic [2:0] OP_ADD  = 3'b101;
  localparam logic [2:0] OP_SUB  = 3'b110;
  localparam logic [2:0] OP_TWOS = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] work;
  logic [CW-1:0]    cnt;

  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] alu_r;
  logic             alu_c;
  logic             alu_v;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] shl_next;
  logic [CW-1:0]    shamt;

  assign in_ready = (state == IDLE);
  assign opa      = acc_sel ? acc : a;
  assign shl_next = work << 1;

  // Shifting by WIDTH or more always clears the word, so the
  // iteration count saturates at WIDTH.
  assign shamt = (b >= WIDTH'(WIDTH)) ? CW'(WIDTH)
                                      : b[CW-1:0];

  always_comb begin
    sum   = '0;
    alu_r = '0;
    alu_c = 1'b0;
    alu_v = 1'b0;
    unique case (1'b1)
      (op == OP_AND): alu_r = opa & b;
      (op == OP_NOT): alu_r = ~opa;
      (op == OP_OR):  alu_r = opa | b;
      (op == OP_XOR): alu_r = opa ^ b;
      // Only reaches the result for a zero shift amount.
      (op == OP_SHL): alu_r = opa;
      (op == OP_ADD): begin
        sum   = {1'b0, opa} + {1'b0, b};
        alu_r = sum[WIDTH-1:0];
        alu_c = sum[WIDTH];
        alu_v = (opa[WIDTH-1] == b[WIDTH-1]) &&
                (alu_r[WIDTH-1] != opa[WIDTH-1]);
      end
      (op == OP_SUB): begin
        alu_r = opa - b;
        alu_c = (opa < b);
        alu_v = (opa[WIDTH-1] != b[WIDTH-1]) &&
                (alu_r[WIDTH-1] != opa[WIDTH-1]);
      end
      (op == OP_TWOS): begin
        alu_r = ~opa + WIDTH'(1);
        alu_c = (opa == '0);
        alu_v = (opa == MINV);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      acc       <= '0;
      work      <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      result    <= '0;
      carry     <= 1'b0;
      zero      <= 1'b0;
      negative  <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (op == OP_SHL && shamt != '0) begin
              work  <= opa;
              cnt   <= shamt;
              state <= SHIFT;
            end else begin
              result    <= alu_r;
              carry     <= alu_c;
              overflow  <= alu_v;
              zero      <= (alu_r == '0);
              negative  <= alu_r[WIDTH-1];
              out_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end
        SHIFT: begin
          work  <= shl_next;
          carry <= work[WIDTH-1];
          cnt   <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            result    <= shl_next;
            zero      <= (shl_next == '0);
            negative  <= shl_next[WIDTH-1];
            overflow  <= 1'b0;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            acc       <= result;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
